// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: default element
// width, the bias/activation FSM encoding and saturation bounds.
package nn_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/bias_relu_pe.sv
// Combinational per-element unit: signed bias add with saturation, then
// optional ReLU clamp of negative results to zero.
module bias_relu_pe
  import nn_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic signed [WIDTH-1:0] elem_i,
  input  logic signed [WIDTH-1:0] bias_i,
  input  logic                    relu_en_i,
  output logic signed [WIDTH-1:0] result_o
);

  localparam logic signed [WIDTH-1:0] MAXV = WIDTH'(sat_max(WIDTH));
  localparam logic signed [WIDTH-1:0] MINV = WIDTH'(sat_min(WIDTH));

  // One guard bit is enough: overflow shows up as the top two sum bits differing.
  function automatic logic signed [WIDTH-1:0] sat_add(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1]) begin
      return s[WIDTH] ? MINV : MAXV;
    end
    return s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] relu(
    input logic signed [WIDTH-1:0] x,
    input logic                    en
  );
    return (en && x[WIDTH-1]) ? '0 : x;
  endfunction

  logic signed [WIDTH-1:0] sum;

  assign sum      = sat_add(elem_i, bias_i);
  assign result_o = relu(sum, relu_en_i);

endmodule

// File: rtl/bias_act_stage.sv
// Bias + activation stage behind mvm: captures a result vector on start, walks
// its elements through one shared bias_relu_pe and publishes the packed result.
module bias_act_stage
  import nn_pkg::*;
#(
  parameter int MATRIX_ROWS = 3,
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int IDX_W       = (MATRIX_ROWS > 1) ? $clog2(MATRIX_ROWS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [MATRIX_ROWS*WIDTH-1:0] in_vector,
  input  logic [MATRIX_ROWS*WIDTH-1:0] bias,
  input  logic                         relu_en,
  output logic [MATRIX_ROWS*WIDTH-1:0] result_vector,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_ROWS - 1);

  state_e                         state_q;
  logic [IDX_W-1:0]               idx_q;
  logic                           relu_q;
  logic signed [WIDTH-1:0]        in_q   [MATRIX_ROWS];
  logic signed [WIDTH-1:0]        bias_q [MATRIX_ROWS];
  logic signed [WIDTH-1:0]        work_q [MATRIX_ROWS];
  logic [MATRIX_ROWS*WIDTH-1:0]   result_q;
  logic [MATRIX_ROWS*WIDTH-1:0]   result_d;
  logic                           done_q;
  logic                           overrun_q;
  logic signed [WIDTH-1:0]        pe_out;

  bias_relu_pe #(
    .WIDTH(WIDTH)
  ) u_pe (
    .elem_i    (in_q[idx_q]),
    .bias_i    (bias_q[idx_q]),
    .relu_en_i (relu_q),
    .result_o  (pe_out)
  );

  // The last element bypasses the working register so the packed result is
  // already complete in the cycle done is high.
  always_comb begin
    result_d = '0;
    for (int i = 0; i < MATRIX_ROWS; i++) begin
      result_d[(MATRIX_ROWS-i)*WIDTH-1 -: WIDTH] =
        (idx_q == IDX_W'(i)) ? pe_out : work_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      relu_q    <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < MATRIX_ROWS; i++) begin
        in_q[i]   <= '0;
        bias_q[i] <= '0;
        work_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (start && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < MATRIX_ROWS; i++) begin
              in_q[i]   <= in_vector[(MATRIX_ROWS-i)*WIDTH-1 -: WIDTH];
              bias_q[i] <= bias[(MATRIX_ROWS-i)*WIDTH-1 -: WIDTH];
            end
            relu_q  <= relu_en;
            idx_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          work_q[idx_q] <= pe_out;
          if (idx_q == LAST_IDX) begin
            result_q <= result_d;
            done_q   <= 1'b1;
            state_q  <= ST_FIN;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign result_vector = result_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_bias_act_stage.sv
// Self-checking bench for bias_act_stage: directed corner vectors, randomized
// operations against an integer reference model, overrun and reset-abort cases.
module tb_bias_act_stage;

  localparam int ROWS = 3;
  localparam int W    = 8;
  localparam int VW   = ROWS * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [VW-1:0] in_vector;
  logic [VW-1:0] bias;
  logic          relu_en;
  logic [VW-1:0] result_vector;
  logic          busy;
  logic          done;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  bias_act_stage #(
    .MATRIX_ROWS(ROWS),
    .WIDTH      (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_vector    (in_vector),
    .bias         (bias),
    .relu_en      (relu_en),
    .result_vector(result_vector),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer add, clamp to the signed range, then ReLU.
  function automatic logic [VW-1:0] model(input logic [VW-1:0] v, input logic [VW-1:0] b,
                                          input logic r);
    logic [VW-1:0] o;
    logic [W-1:0]  ev;
    logic [W-1:0]  bv;
    int            s;
    int            lo;
    int            hi;
    lo = -(1 << (W - 1));
    hi = (1 << (W - 1)) - 1;
    o  = '0;
    for (int i = 0; i < ROWS; i++) begin
      ev = v[(ROWS-i)*W-1 -: W];
      bv = b[(ROWS-i)*W-1 -: W];
      s  = int'($signed(ev)) + int'($signed(bv));
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      if (r && s < 0) s = 0;
      o[(ROWS-i)*W-1 -: W] = W'(s);
    end
    return o;
  endfunction

  // Drives start in the next cycle and checks busy/done timing and the result.
  task automatic run_op(input string tag, input logic [VW-1:0] v, input logic [VW-1:0] b,
                        input logic r, input logic [VW-1:0] exp);
    @(negedge clk);
    start     = 1'b1;
    in_vector = v;
    bias      = b;
    relu_en   = r;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start     = 1'b0;
      in_vector = '0;
      bias      = '0;
      relu_en   = 1'b0;
      if (k < 4) begin
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_early_done"}, 64'(done), 64'd0);
      end else begin
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_result"}, 64'(result_vector), 64'(exp));
      end
    end
  endtask

  logic [VW-1:0] rv;
  logic [VW-1:0] rb;
  logic          rr;
  logic [VW-1:0] keep;

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    in_vector = '0;
    bias      = '0;
    relu_en   = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_result", 64'(result_vector), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_op("nosat", 24'h0E2032, 24'h010203, 1'b1, 24'h0F2235);
    @(negedge clk);
    chk("nosat_done_pulse", 64'(done), 64'd0);
    chk("nosat_idle", 64'(busy), 64'd0);
    chk("nosat_hold", 64'(result_vector), 64'h0F2235);

    // Back-to-back: each call starts in the cycle right after the previous FIN.
    run_op("possat", 24'h7F50F0, 24'h012020, 1'b0, 24'h7F7010);
    run_op("relu_on", 24'h9000FF, 24'h0000FF, 1'b1, 24'h000000);
    run_op("relu_off", 24'h9000FF, 24'h0000FF, 1'b0, 24'h9000FE);
    run_op("negsat", 24'h80017F, 24'hFF8080, 1'b0, 24'h8081FF);
    chk("b2b_overrun", 64'(overrun), 64'd0);

    for (int n = 0; n < 24; n++) begin
      rv = VW'({$urandom, $urandom});
      rb = VW'($urandom);
      rr = 1'($urandom_range(0, 1));
      if (n % 4 == 0) rb = {ROWS{8'h7F}};
      if (n % 4 == 1) rb = {ROWS{8'h80}};
      run_op($sformatf("rand%0d", n), rv, rb, rr, model(rv, rb, rr));
    end
    chk("rand_overrun", 64'(overrun), 64'd0);

    // Overrun: a second start two cycles in is ignored but flagged.
    @(negedge clk);
    rv   = 24'h102030;
    rb   = 24'h010101;
    keep = model(rv, rb, 1'b0);
    start = 1'b1; in_vector = rv; bias = rb; relu_en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0; in_vector = '0; bias = '0;
      if (k == 2) begin
        start = 1'b1; in_vector = 24'h7F7F7F; bias = 24'h7F7F7F; relu_en = 1'b1;
      end
      if (k == 3) chk("ovr_flag", 64'(overrun), 64'd1);
      if (k == 4) begin
        chk("ovr_done", 64'(done), 64'd1);
        chk("ovr_result", 64'(result_vector), 64'(keep));
      end
      if (k > 4) chk("ovr_single_done", 64'(done), 64'd0);
    end
    chk("ovr_sticky", 64'(overrun), 64'd1);
    chk("ovr_result_hold", 64'(result_vector), 64'(keep));

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    start = 1'b1; in_vector = 24'h112233; bias = 24'h010101; relu_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_result", 64'(result_vector), 64'd0);
    chk("abort_overrun", 64'(overrun), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_done", 64'(done), 64'd0);
    end
    run_op("after_abort", 24'hC0407F, 24'h10F001, 1'b1, model(24'hC0407F, 24'h10F001, 1'b1));
    chk("after_abort_overrun", 64'(overrun), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
